// File: rtl/led_fx_pkg.sv
// Shared definitions for the LED effect blocks (PISO transmitter, SIPO sinks,
// rate dividers).
//   LED_WIDTH   : default pattern width (one 8-LED shift register)
//   DEFAULT_DIV : default clocks per serial bit
//   led_state_e : IDLE / SHIFT state encoding
//   cnt_width() : counter width for a 0..n-1 count, never narrower than 1 bit
package led_fx_pkg;

    localparam int LED_WIDTH   = 8;
    localparam int DEFAULT_DIV = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } led_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Rate divider: counts 0..DIV-1 while enabled and pulses tick_o on the last
// count, then wraps. Used as the bit-period timer and for effect rates.
//   clk      : clock
//   reset    : asynchronous, active-high
//   clear_i  : force the count back to 0 (wins over enable_i)
//   enable_i : advance the count
//   tick_o   : high while enabled and the count is DIV-1
module led_tick_div
    import led_fx_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    // With DIV=1 the count is pinned at 0, so every enabled cycle ticks.
    assign at_end = (cnt_q == CW'(DIV - 1));
    assign tick_o = enable_i && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_piso_tx.sv
// Parallel-in serial-out transmitter for LED effect shift registers.
// A word taken through the valid/ready handshake is shifted out one bit per
// DIV clocks; bit_strobe_o marks the clock on which a downstream SIPO samples.
//   clk          : clock
//   reset        : asynchronous, active-high
//   load_valid_i : load_data_i is offered
//   load_ready_o : a word can be accepted this cycle
//   load_data_i  : parallel pattern
//   s_out_o      : serial data (driven from registers only)
//   bit_strobe_o : one-cycle pulse on the last clock of each bit period
//   busy_o       : a word is being shifted
//   done_o       : one-cycle pulse with the final bit_strobe_o of a word
module led_piso_tx
    import led_fx_pkg::*;
#(
    parameter int WIDTH     = LED_WIDTH,
    parameter int DIV       = DEFAULT_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             s_out_o,
    output logic             bit_strobe_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = cnt_width(WIDTH);

    led_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shifting;
    logic             tick;
    logic             last_bit;
    logic             accept;
    logic             out_bit;

    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = (cnt_q == '0);
    assign accept   = load_valid_i && load_ready_o;
    assign out_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    // Clearing on every accept restarts the bit period for a fresh word; on a
    // gapless handover the divider is wrapping to 0 anyway.
    led_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (shifting),
        .tick_o   (tick)
    );

    assign bit_strobe_o = tick;
    assign done_o       = tick && last_bit;
    // Ready during the final strobe lets the next word follow with no bubble.
    assign load_ready_o = !shifting || done_o;
    assign busy_o       = shifting;
    assign s_out_o      = shifting && out_bit;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SHIFT: begin
                if (tick) begin
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                    if (last_bit) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = load_data_i;
            cnt_d   = CW'(WIDTH - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
